// File: rtl/program_counter_unit.sv
// Program counter unit: owns the architectural PC, turns pc_src into the next PC, issues fetches.
// Latency: an advance in Issued shows the new fetch_addr with fetch_valid=1 on the next cycle.
// Backpressure: fetch_addr holds while fetch_valid && !fetch_ready_i; one early advance is buffered, further ones set overrun.
//
// Ports:
//   clock_i, reset_n_i        clock and synchronous active-low reset
//   advance_i                 current instruction done; compute and commit the next PC
//   pc_src_i, jalr_i, imm_i,  next-PC selection and operands
//   read_data_1_i, mepc_i,
//   sepc_i, trap_i,
//   trap_addr_i
//   fetch_valid_o/fetch_ready_i/fetch_addr_o   instruction-fetch request handshake
//   pc_o, pc_plus_4_o         current PC and PC+4 (modulo 2^Width)
//   misaligned_o              one-cycle pulse: computed target misaligned, PC not updated
//   overrun_o                 sticky: advance arrived while the pending slot was already full
//
// Optional feature macro PC_UNIT_COMPRESSED_EN: adds compressed_i; the sequential target becomes
// pc+2 for compressed instructions and only bit 0 of the target is checked for alignment.

package program_counter_unit_pkg;
  typedef enum logic [1:0] {
    PcPlus4             = 2'd0,
    PcOrReadDataPlusImm = 2'd1,
    Mepc                = 2'd2,
    Sepc                = 2'd3
  } pc_src_t;
endpackage

module program_counter_unit
  import program_counter_unit_pkg::*;
#(
  parameter int unsigned      Width        = 64,
  parameter logic [Width-1:0] ResetAddress = '0
) (
  input  logic             clock_i,
  input  logic             reset_n_i,
  input  logic             advance_i,
  input  pc_src_t          pc_src_i,
  input  logic             jalr_i,
  input  logic [Width-1:0] imm_i,
  input  logic [Width-1:0] read_data_1_i,
  input  logic [Width-1:0] mepc_i,
  input  logic [Width-1:0] sepc_i,
  input  logic             trap_i,
  input  logic [Width-1:0] trap_addr_i,
`ifdef PC_UNIT_COMPRESSED_EN
  input  logic             compressed_i,
`endif
  output logic             fetch_valid_o,
  input  logic             fetch_ready_i,
  output logic [Width-1:0] fetch_addr_o,
  output logic [Width-1:0] pc_o,
  output logic [Width-1:0] pc_plus_4_o,
  output logic             misaligned_o,
  output logic             overrun_o
);

  typedef enum logic [1:0] {
    Boot   = 2'd0,
    Fetch  = 2'd1,
    Issued = 2'd2
  } state_t;

  state_t           state_q;
  logic [Width-1:0] pc_q;
  logic             pend_vld_q;
  logic [Width-1:0] pend_pc_q;
  logic             fetch_valid_q;
  logic             misaligned_q;
  logic             overrun_q;

  logic [Width-1:0] pc_plus_4;
  logic [Width-1:0] seq_target;
  logic [Width-1:0] jump_base;
  logic [Width-1:0] jump_sum;
  logic [Width-1:0] target;
  logic             target_misaligned;

  assign pc_plus_4 = pc_q + Width'(4);

  // Next-PC selection; trap always wins over the decoder's selection.
  always_comb begin
    seq_target = pc_plus_4;
`ifdef PC_UNIT_COMPRESSED_EN
    if (compressed_i) begin
      seq_target = pc_q + Width'(2);
    end
`endif
    jump_base = jalr_i ? read_data_1_i : pc_q;
    jump_sum  = jump_base + imm_i;
    // Register-indirect jumps discard bit 0 of the computed address.
    if (jalr_i) begin
      jump_sum[0] = 1'b0;
    end
    target = seq_target;
    if (trap_i) begin
      target = trap_addr_i;
    end else begin
      unique case (pc_src_i)
        PcPlus4:             target = seq_target;
        PcOrReadDataPlusImm: target = jump_sum;
        Mepc:                target = mepc_i;
        Sepc:                target = sepc_i;
        default:             target = seq_target;
      endcase
    end
  end

`ifdef PC_UNIT_COMPRESSED_EN
  assign target_misaligned = target[0];
`else
  assign target_misaligned = |target[1:0];
`endif

  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      state_q       <= Boot;
      pc_q          <= ResetAddress;
      pend_vld_q    <= 1'b0;
      pend_pc_q     <= '0;
      fetch_valid_q <= 1'b0;
      misaligned_q  <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      misaligned_q <= 1'b0;
      unique case (state_q)
        Boot: begin
          // advance is ignored here: there is no instruction in flight yet.
          state_q       <= Fetch;
          fetch_valid_q <= 1'b1;
        end

        Fetch: begin
          if (fetch_ready_i) begin
            if (pend_vld_q) begin
              // An early advance was buffered: immediately request its target.
              pc_q       <= pend_pc_q;
              pend_vld_q <= 1'b0;
            end else begin
              state_q       <= Issued;
              fetch_valid_q <= 1'b0;
            end
          end
          // Later assignments below intentionally override the handshake result.
          if (advance_i) begin
            if (target_misaligned) begin
              misaligned_q <= 1'b1;
            end else if (pend_vld_q) begin
              overrun_q <= 1'b1;
            end else if (fetch_ready_i) begin
              // Handshake completes this cycle: redirect straight into a new request.
              pc_q          <= target;
              state_q       <= Fetch;
              fetch_valid_q <= 1'b1;
            end else begin
              pend_vld_q <= 1'b1;
              pend_pc_q  <= target;
            end
          end
        end

        Issued: begin
          if (advance_i) begin
            if (target_misaligned) begin
              misaligned_q <= 1'b1;
            end else begin
              pc_q          <= target;
              state_q       <= Fetch;
              fetch_valid_q <= 1'b1;
            end
          end
        end

        default: begin
          state_q       <= Boot;
          fetch_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign fetch_valid_o = fetch_valid_q;
  assign fetch_addr_o  = pc_q;
  assign pc_o          = pc_q;
  assign pc_plus_4_o   = pc_plus_4;
  assign misaligned_o  = misaligned_q;
  assign overrun_o     = overrun_q;

endmodule

// File: tb/tb_program_counter_unit.sv
// Bench for program_counter_unit: directed vectors with literal expectations, plus a
// transaction-level model (expected fetch-address queue, pending slot, sticky overrun)
// checked on every falling clock edge.
// Inputs change 1ns after the rising edge; everything is sampled on the falling edge.

module tb_program_counter_unit;
  import program_counter_unit_pkg::*;

  localparam logic [63:0] RA = 64'h1000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        advance;
  pc_src_t     pc_src;
  logic        jalr;
  logic [63:0] imm;
  logic [63:0] read_data_1;
  logic [63:0] mepc;
  logic [63:0] sepc;
  logic        trap;
  logic [63:0] trap_addr;
`ifdef PC_UNIT_COMPRESSED_EN
  logic        compressed;
`endif
  logic        fetch_valid;
  logic        fetch_ready;
  logic [63:0] fetch_addr;
  logic [63:0] pc;
  logic [63:0] pc_plus_4;
  logic        misaligned;
  logic        overrun;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  program_counter_unit #(
    .Width       (64),
    .ResetAddress(RA)
  ) dut (
    .clock_i      (clk),
    .reset_n_i    (reset_n),
    .advance_i    (advance),
    .pc_src_i     (pc_src),
    .jalr_i       (jalr),
    .imm_i        (imm),
    .read_data_1_i(read_data_1),
    .mepc_i       (mepc),
    .sepc_i       (sepc),
    .trap_i       (trap),
    .trap_addr_i  (trap_addr),
`ifdef PC_UNIT_COMPRESSED_EN
    .compressed_i (compressed),
`endif
    .fetch_valid_o(fetch_valid),
    .fetch_ready_i(fetch_ready),
    .fetch_addr_o (fetch_addr),
    .pc_o         (pc),
    .pc_plus_4_o  (pc_plus_4),
    .misaligned_o (misaligned),
    .overrun_o    (overrun)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Next-PC rules written directly from the selection table.
  function automatic logic [63:0] model_target(input logic [63:0] cur);
    logic [63:0] r;
    if (trap) return trap_addr;
`ifdef PC_UNIT_COMPRESSED_EN
    if (pc_src == PcPlus4 && compressed) return cur + 64'd2;
`endif
    case (pc_src)
      PcPlus4:             r = cur + 64'd4;
      PcOrReadDataPlusImm: r = jalr ? ((read_data_1 + imm) & ~64'd1) : (cur + imm);
      Mepc:                r = mepc;
      default:             r = sepc;
    endcase
    return r;
  endfunction

  function automatic logic model_misaligned(input logic [63:0] a);
`ifdef PC_UNIT_COMPRESSED_EN
    return a[0];
`else
    return a[1:0] != 2'b00;
`endif
  endfunction

  // Transaction-level model state.
  logic [63:0] exp_q[$];
  logic [63:0] mpc;
  logic        pend_full;
  logic [63:0] pend_addr;
  logic        exp_mis;
  logic        exp_ovr;
  logic        booted;
  logic        started = 1'b0;
  logic        rst_prev;
  logic        lat_vld;
  logic [63:0] lat_addr;
  logic        hold_vld;
  logic [63:0] hold_pc;
  logic        stall_prev;
  logic [63:0] stall_addr;
  logic [63:0] m_t;
  logic        m_hs;
  logic        m_old_pf;

  always @(negedge clk) begin
    if (started) begin
      check("addr_eq_pc", fetch_addr, pc);
      check("pc_plus_4", pc_plus_4, pc + 64'd4);
      check("misaligned", 64'(misaligned), 64'(exp_mis));
      check("overrun", 64'(overrun), 64'(exp_ovr));
      if (rst_prev) begin
        check("reset_valid", 64'(fetch_valid), 64'd0);
        check("reset_pc", pc, RA);
      end
      if (stall_prev) begin
        check("stall_valid", 64'(fetch_valid), 64'd1);
        check("stall_addr", fetch_addr, stall_addr);
      end
      if (lat_vld) begin
        check("latency_valid", 64'(fetch_valid), 64'd1);
        check("latency_addr", fetch_addr, lat_addr);
      end
      if (hold_vld) begin
        check("mis_hold_valid", 64'(fetch_valid), 64'd0);
        check("mis_hold_pc", pc, hold_pc);
      end
      if (booted && !fetch_valid && !rst_prev) check("issued_pc", pc, mpc);
      if (reset_n && fetch_valid && fetch_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL fetch_seq: got unexpected fetch 0x%0h, expected none", fetch_addr);
        end else begin
          check("fetch_seq", fetch_addr, exp_q.pop_front());
        end
      end
    end

    // Advance the model to what must hold after the coming rising edge.
    if (!reset_n) begin
      started    = 1'b1;
      rst_prev   = 1'b1;
      mpc        = RA;
      pend_full  = 1'b0;
      exp_q.delete();
      exp_q.push_back(RA);
      exp_mis    = 1'b0;
      exp_ovr    = 1'b0;
      booted     = 1'b0;
      lat_vld    = 1'b0;
      hold_vld   = 1'b0;
      stall_prev = 1'b0;
    end else if (started) begin
      rst_prev   = 1'b0;
      if (fetch_valid) booted = 1'b1;
      m_hs       = fetch_valid && fetch_ready;
      stall_prev = fetch_valid && !fetch_ready;
      stall_addr = fetch_addr;
      m_t        = model_target(mpc);
      m_old_pf   = pend_full;
      exp_mis    = 1'b0;
      lat_vld    = 1'b0;
      hold_vld   = 1'b0;
      if (m_hs && m_old_pf) begin
        mpc       = pend_addr;
        pend_full = 1'b0;
      end
      if (advance && booted) begin
        if (model_misaligned(m_t)) begin
          exp_mis = 1'b1;
          if (!fetch_valid) begin
            hold_vld = 1'b1;
            hold_pc  = mpc;
          end
        end else if (!fetch_valid || (fetch_ready && !m_old_pf)) begin
          mpc      = m_t;
          exp_q.push_back(m_t);
          lat_vld  = 1'b1;
          lat_addr = m_t;
        end else if (m_old_pf) begin
          exp_ovr = 1'b1;
        end else begin
          pend_full = 1'b1;
          pend_addr = m_t;
          exp_q.push_back(m_t);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input pc_src_t s, input logic j, input logic [63:0] im,
                         input logic [63:0] rd1);
    pc_src      = s;
    jalr        = j;
    imm         = im;
    read_data_1 = rd1;
    trap        = 1'b0;
  endtask

  // From Issued: one advance, check the new request, let it be accepted (back to Issued).
  task automatic adv_expect(input string nm, input logic [63:0] exp_addr);
    advance = 1'b1;
    step();
    advance = 1'b0;
    @(negedge clk);
    check({nm, "_valid"}, 64'(fetch_valid), 64'd1);
    check({nm, "_addr"}, fetch_addr, exp_addr);
    step();
  endtask

  initial begin
    #100000;
    $display("watchdog expired before the bench completed");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n     = 1'b0;
    advance     = 1'b0;
    fetch_ready = 1'b1;
    pc_src      = PcPlus4;
    jalr        = 1'b0;
    imm         = '0;
    read_data_1 = '0;
    mepc        = '0;
    sepc        = '0;
    trap        = 1'b0;
    trap_addr   = '0;
`ifdef PC_UNIT_COMPRESSED_EN
    compressed  = 1'b0;
`endif
    repeat (3) step();
    @(negedge clk);
    check("rst_pc", pc, 64'h1000);
    check("rst_valid", 64'(fetch_valid), 64'd0);
    step();
    reset_n = 1'b1;
    @(negedge clk);
    check("boot_valid", 64'(fetch_valid), 64'd0);
    step();
    @(negedge clk);
    check("boot_fetch_valid", 64'(fetch_valid), 64'd1);
    check("boot_fetch_addr", fetch_addr, 64'h1000);
    step();
    @(negedge clk);
    check("issued_idle", 64'(fetch_valid), 64'd0);
    step();

    set_ops(PcPlus4, 1'b0, 64'd0, 64'd0);
    adv_expect("plus4", 64'h1004);
    set_ops(PcOrReadDataPlusImm, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 64'd0);
    adv_expect("jal_neg", 64'h1000);
    set_ops(PcPlus4, 1'b0, 64'd0, 64'd0);
    adv_expect("plus4_b", 64'h1004);
    set_ops(PcOrReadDataPlusImm, 1'b1, 64'h10, 64'h2001);
    adv_expect("jalr", 64'h2010);
    set_ops(Mepc, 1'b0, 64'd0, 64'd0);
    mepc      = 64'h3000;
    trap      = 1'b1;
    trap_addr = 64'h8000;
    adv_expect("trap", 64'h8000);
    trap = 1'b0;
    adv_expect("mepc", 64'h3000);
    set_ops(Sepc, 1'b0, 64'd0, 64'd0);
    sepc = 64'h4000;
    adv_expect("sepc", 64'h4000);
    set_ops(PcOrReadDataPlusImm, 1'b1, 64'd0, 64'h1000);
    adv_expect("jalr_home", 64'h1000);

    // Misaligned target from Issued: pulse, no PC change, no request.
    set_ops(PcOrReadDataPlusImm, 1'b0, 64'h6, 64'd0);
    advance = 1'b1;
    step();
    advance = 1'b0;
    @(negedge clk);
    check("mis_pulse", 64'(misaligned), 64'd1);
    check("mis_no_fetch", 64'(fetch_valid), 64'd0);
    check("mis_pc", pc, 64'h1000);
    step();
    @(negedge clk);
    check("mis_pulse_end", 64'(misaligned), 64'd0);
    step();

    // Stalled fetch of 0x1000 with one early advance buffered, then an overrun.
    fetch_ready = 1'b0;
    set_ops(PcOrReadDataPlusImm, 1'b1, 64'd0, 64'h1000);
    advance = 1'b1;
    step();
    set_ops(PcPlus4, 1'b0, 64'd0, 64'd0);
    step();
    advance = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("stall_hold_addr", fetch_addr, 64'h1000);
      check("stall_no_ovr", 64'(overrun), 64'd0);
      step();
    end
    advance = 1'b1;
    step();
    advance = 1'b0;
    @(negedge clk);
    check("overrun_set", 64'(overrun), 64'd1);
    check("overrun_addr", fetch_addr, 64'h1000);
    step();
    fetch_ready = 1'b1;
    step();
    @(negedge clk);
    check("drain_valid", 64'(fetch_valid), 64'd1);
    check("drain_addr", fetch_addr, 64'h1004);
    step();
    @(negedge clk);
    check("drain_idle", 64'(fetch_valid), 64'd0);
    check("overrun_sticky", 64'(overrun), 64'd1);
    step();

    // Advance coinciding with an accepted fetch and an empty pending slot.
    set_ops(PcPlus4, 1'b0, 64'd0, 64'd0);
    advance = 1'b1;
    step();
    @(negedge clk);
    check("b2b_first", fetch_addr, 64'h1008);
    step();
    advance = 1'b0;
    @(negedge clk);
    check("b2b_second_valid", 64'(fetch_valid), 64'd1);
    check("b2b_second", fetch_addr, 64'h100C);
    step();

    // Reset clears the sticky overrun and returns to the reset address.
    reset_n = 1'b0;
    step();
    @(negedge clk);
    check("rst2_overrun", 64'(overrun), 64'd0);
    check("rst2_pc", pc, 64'h1000);
    check("rst2_valid", 64'(fetch_valid), 64'd0);
    step();
    reset_n = 1'b1;
    repeat (4) step();
    @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
